// File: rtl/snake_dir_input.sv
// Direction input front end for the snake core: synchronises and debounces the
// four buttons, filters illegal turns and queues legal ones until the next move.
module snake_dir_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned CW              = 3
) (
    input  logic          CLK_100MHz,
    input  logic          reset,
    input  logic          restart,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          step,
    output logic [1:0]    dir_out,
    output logic [CW-1:0] q_count,
    output logic          overflow
);

    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    localparam logic [1:0] DirR = 2'd0;
    localparam logic [1:0] DirU = 2'd1;
    localparam logic [1:0] DirD = 2'd2;
    localparam logic [1:0] DirL = 2'd3;

    // Buttons are indexed by their direction code so a pulse index is the command.
    logic [3:0] btn_raw;
    assign btn_raw = {btn_left, btn_down, btn_up, btn_right};

    logic [3:0]     sync1_q, sync1_d;
    logic [3:0]     sync2_q, sync2_d;
    logic [3:0]     db_q, db_d;
    logic [3:0]     press_q, press_d;
    logic [DBW-1:0] cnt_q [4];
    logic [DBW-1:0] cnt_d [4];

    logic [1:0]     fifo_q [QUEUE_DEPTH];
    logic [1:0]     fifo_d [QUEUE_DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     dir_q, dir_d;
    logic           overflow_q, overflow_d;

    // Synchroniser, debounce counters and press edge detection.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = db_d & ~db_q;
    end

    logic       cand_valid;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic [PW-1:0] last_idx;
    logic       legal;
    logic       full;
    logic       pop;
    logic       push;

    // Arbitration, legality against the reference heading, and queue control.
    always_comb begin
        cand_valid = |press_q;
        cand       = DirL;
        if (press_q[DirU]) begin
            cand = DirU;
        end else if (press_q[DirD]) begin
            cand = DirD;
        end else if (press_q[DirR]) begin
            cand = DirR;
        end

        last_idx = tail_q - 1'b1;
        ref_dir  = (count_q != '0) ? fifo_q[last_idx] : dir_q;
        legal    = cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'b11));
        full     = (count_q == CW'(QUEUE_DEPTH));
        pop      = step && (count_q != '0);
        // A pop in the same cycle frees a slot, so a full queue still accepts.
        push     = legal && (!full || pop);

        fifo_d     = fifo_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        dir_d      = dir_q;
        overflow_d = overflow_q | (legal && full && !pop);

        if (push) begin
            fifo_d[tail_q] = cand;
            tail_d         = tail_q + 1'b1;
        end
        if (pop) begin
            dir_d  = fifo_q[head_q];
            head_d = head_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // Restart resets game-side state only; debouncers keep held buttons quiet.
        if (restart) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            dir_d      = DirR;
            overflow_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            press_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            for (int j = 0; j < QUEUE_DEPTH; j++) begin
                fifo_q[j] <= DirR;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            dir_q      <= DirR;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            press_q    <= press_d;
            cnt_q      <= cnt_d;
            fifo_q     <= fifo_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            overflow_q <= overflow_d;
        end
    end

    // Registered outputs.
    always_comb begin
        dir_out  = dir_q;
        q_count  = count_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed self-checking bench for snake_dir_input with a short debounce time.
module tb_snake_dir_input;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       reset, restart, step;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [1:0] dir_out;
    logic [2:0] q_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_dir_input #(
        .DEBOUNCE_CYCLES(DB),
        .QUEUE_DEPTH    (4),
        .CW             (3)
    ) dut (
        .CLK_100MHz(clk),
        .reset     (reset),
        .restart   (restart),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .step      (step),
        .dir_out   (dir_out),
        .q_count   (q_count),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change just after a rising edge; checks happen on the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // mask bits: {left, down, up, right}
    task automatic set_btn(input logic [3:0] m);
        {btn_left, btn_down, btn_up, btn_right} = m;
    endtask

    task automatic press(input logic [3:0] m);
        set_btn(m);
        cycles(12);
        set_btn(4'b0000);
        cycles(12);
    endtask

    task automatic do_step();
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        cycles(1);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        cycles(1);
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; step = 1'b0;
        set_btn(4'b0000);
        cycles(3);
        reset = 1'b0;
        cycles(1);
        sample();
        check("rst_dir", dir_out, 0);
        check("rst_cnt", q_count, 0);
        check("rst_ovf", overflow, 0);

        // Reset mid-debounce: the held button must fully re-qualify.
        cycles(1);
        set_btn(4'b0010);
        cycles(5);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(4);
        sample();
        check("rstmid_early", q_count, 0);
        cycles(12);
        sample();
        check("rstmid_late", q_count, 1);
        set_btn(4'b0000);
        cycles(12);
        do_restart();

        // Bounce: toggle every 2 cycles for 20 cycles, then hold.
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            cycles(2);
        end
        sample();
        check("bounce_none", q_count, 0);
        btn_up = 1'b1;
        cycles(14);
        sample();
        check("bounce_one", q_count, 1);
        do_step();
        sample();
        check("bounce_dir", dir_out, 1);
        check("bounce_cnt", q_count, 0);
        btn_up = 1'b0;
        cycles(12);

        // Reversal and repeat from r.
        do_restart();
        press(4'b1000);
        press(4'b0001);
        sample();
        check("rev_cnt", q_count, 0);
        do_step();
        sample();
        check("rev_dir", dir_out, 0);

        // Double-tap.
        press(4'b0010);
        press(4'b1000);
        sample();
        check("dbl_cnt", q_count, 2);
        do_step();
        sample();
        check("dbl_dir1", dir_out, 1);
        check("dbl_cnt1", q_count, 1);
        do_step();
        sample();
        check("dbl_dir2", dir_out, 3);
        check("dbl_cnt2", q_count, 0);

        // Overflow: up, left, down, right queued; the final up is dropped.
        do_restart();
        press(4'b0010);
        press(4'b1000);
        press(4'b0100);
        press(4'b0001);
        sample();
        check("ovf_pre", overflow, 0);
        press(4'b0010);
        sample();
        check("ovf_cnt", q_count, 4);
        check("ovf_flag", overflow, 1);
        do_step(); sample(); check("ovf_d0", dir_out, 1);
        do_step(); sample(); check("ovf_d1", dir_out, 3);
        do_step(); sample(); check("ovf_d2", dir_out, 2);
        do_step(); sample(); check("ovf_d3", dir_out, 0);
        check("ovf_empty", q_count, 0);
        check("ovf_sticky", overflow, 1);
        do_step(); sample(); check("ovf_hold", dir_out, 0);

        // Simultaneous up and down: only up survives.
        do_restart();
        check("rs_ovf_clr", overflow, 0);
        press(4'b0110);
        sample();
        check("sim_cnt", q_count, 1);
        do_step();
        sample();
        check("sim_dir", dir_out, 1);
        check("sim_cnt0", q_count, 0);

        // Restart with three entries queued and btn_up held.
        do_restart();
        press(4'b0010);
        press(4'b1000);
        press(4'b0100);
        sample();
        check("rst3_cnt", q_count, 3);
        set_btn(4'b0010);
        cycles(12);
        sample();
        check("rst3_rej", q_count, 3);
        do_restart();
        sample();
        check("rs_dir", dir_out, 0);
        check("rs_cnt", q_count, 0);
        check("rs_ovf", overflow, 0);
        cycles(20);
        sample();
        check("rs_nofire", q_count, 0);
        set_btn(4'b0000);
        cycles(12);
        press(4'b0010);
        sample();
        check("rs_refire", q_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
